// File: rtl/secuenciador_pkg.sv
// Shared definitions for the microprogram sequencer: microword mode
// encodings, FSM states and the bit positions of the microword fields.
package secuenciador_pkg;

  // Sequencing mode carried in microword bits [9:8]
  typedef enum logic [1:0] {
    MODO_ALTO  = 2'b00,
    MODO_SIGUE = 2'b01,
    MODO_SALTO = 2'b10,
    MODO_RAMA  = 2'b11
  } modo_t;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    EJECUTA = 2'd1,
    FIN     = 2'd2
  } estado_t;

  // Microword field positions
  localparam int MODO_MSB     = 9;
  localparam int MODO_LSB     = 8;
  localparam int SEL_COND_MSB = 7;
  localparam int SEL_COND_LSB = 6;
  localparam int DESTINO_MSB  = 5;
  localparam int DESTINO_LSB  = 0;

  // Width of the control field sent to the datapath
  localparam int ANCHO_CTRL = 8;

endpackage

// File: rtl/decodificador_siguiente_dir.sv
// Combinational next-microaddress logic: decodes the mode of the current
// microword and selects the following microPC, flags whether the control
// field must be loaded and whether the microword ends the program.
module decodificador_siguiente_dir
  import secuenciador_pkg::*;
#(
  parameter int ANCHO_DIR = 6
) (
  input  modo_t                  modo,
  input  logic [ANCHO_CTRL-1:0]  campo,
  input  logic [3:0]             condicion,
  input  logic [ANCHO_DIR-1:0]   upc,
  output logic [ANCHO_DIR-1:0]   sig_upc,
  output logic                   carga_control,
  output logic                   es_alto
);

  logic [ANCHO_DIR-1:0] destino;
  logic [1:0]           sel_cond;

  // Next-address selection; sequential increment wraps naturally at 2^ANCHO_DIR
  always_comb begin
    destino       = ANCHO_DIR'(campo[DESTINO_MSB:DESTINO_LSB]);
    sel_cond      = campo[SEL_COND_MSB:SEL_COND_LSB];
    sig_upc       = upc + 1'b1;
    carga_control = 1'b0;
    es_alto       = 1'b0;
    case (modo)
      MODO_ALTO: begin
        es_alto = 1'b1;
        sig_upc = upc;
      end
      MODO_SIGUE: begin
        carga_control = 1'b1;
      end
      MODO_SALTO: begin
        sig_upc = destino;
      end
      MODO_RAMA: begin
        if (condicion[sel_cond]) begin
          sig_upc = destino;
        end
      end
      default: begin
        sig_upc = upc;
      end
    endcase
  end

endmodule

// File: rtl/secuenciador_micro.sv
// Microprogram sequencer. Presents the registered microPC to a combinational
// microprogram memory, decodes the returned microword in the same cycle
// (one microinstruction per cycle, no fetch bubble) and registers the
// control field for the datapath. Start/done handshake via Inicio/Fin.
// Optional watchdog step limit enabled with macro SEC_WATCHDOG_EN, which
// adds the MAX_PASOS parameter and the sticky Error_Watchdog output.
module secuenciador_micro
  import secuenciador_pkg::*;
#(
  parameter int ANCHO_DIR  = 6,
  parameter int ANCHO_DATO = 10,
  parameter int DIR_INICIO = 0
`ifdef SEC_WATCHDOG_EN
  ,
  parameter int MAX_PASOS  = 255
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Inicio,
  input  logic [3:0]            Condicion,
  input  logic [ANCHO_DATO-1:0] Data_Memoria_Micro,
  output logic [ANCHO_DIR-1:0]  Dir_Memoria_Micro,
  output logic [ANCHO_CTRL-1:0] Control_Out,
  output logic                  Ocupado,
  output logic                  Fin
`ifdef SEC_WATCHDOG_EN
  ,
  output logic                  Error_Watchdog
`endif
);

  localparam logic [ANCHO_DIR-1:0] DIR_INI = DIR_INICIO[ANCHO_DIR-1:0];

  estado_t               estado_reg;
  logic [ANCHO_DIR-1:0]  upc_reg;
  logic [ANCHO_CTRL-1:0] control_reg;
  logic                  ocupado_reg;
  logic                  fin_reg;

  modo_t                 modo_actual;
  logic [ANCHO_CTRL-1:0] campo_actual;
  logic [ANCHO_DIR-1:0]  sig_upc;
  logic                  carga_control;
  logic                  es_alto;
  logic                  vence;

  assign modo_actual  = modo_t'(Data_Memoria_Micro[MODO_MSB:MODO_LSB]);
  assign campo_actual = Data_Memoria_Micro[ANCHO_CTRL-1:0];

  decodificador_siguiente_dir #(
    .ANCHO_DIR (ANCHO_DIR)
  ) u_decodificador (
    .modo          (modo_actual),
    .campo         (campo_actual),
    .condicion     (Condicion),
    .upc           (upc_reg),
    .sig_upc       (sig_upc),
    .carga_control (carga_control),
    .es_alto       (es_alto)
  );

`ifdef SEC_WATCHDOG_EN
  logic [7:0] pasos_reg;
  logic       error_reg;

  // The current cycle is the MAX_PASOS-th executed step
  assign vence = (pasos_reg + 8'd1) == MAX_PASOS[7:0];

  // Step counter and sticky abort flag; both cleared by an accepted start
  always_ff @(posedge clk) begin
    if (reset) begin
      pasos_reg <= '0;
      error_reg <= 1'b0;
    end else if (estado_reg == REPOSO && Inicio) begin
      pasos_reg <= '0;
      error_reg <= 1'b0;
    end else if (estado_reg == EJECUTA) begin
      pasos_reg <= pasos_reg + 8'd1;
      if (vence && !es_alto) begin
        error_reg <= 1'b1;
      end
    end
  end

  assign Error_Watchdog = error_reg;
`else
  assign vence = 1'b0;
`endif

  // Sequencer FSM with microPC, control field and handshake registers
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_reg  <= REPOSO;
      upc_reg     <= DIR_INI;
      control_reg <= '0;
      ocupado_reg <= 1'b0;
      fin_reg     <= 1'b0;
    end else begin
      fin_reg <= 1'b0;
      case (estado_reg)
        REPOSO: begin
          upc_reg     <= DIR_INI;
          control_reg <= '0;
          if (Inicio) begin
            estado_reg  <= EJECUTA;
            ocupado_reg <= 1'b1;
          end
        end
        EJECUTA: begin
          if (es_alto || vence) begin
            estado_reg  <= FIN;
            fin_reg     <= 1'b1;
            ocupado_reg <= 1'b0;
            control_reg <= '0;
            upc_reg     <= DIR_INI;
          end else begin
            upc_reg <= sig_upc;
            if (carga_control) begin
              control_reg <= campo_actual;
            end
          end
        end
        FIN: begin
          estado_reg  <= REPOSO;
          upc_reg     <= DIR_INI;
          control_reg <= '0;
        end
        default: begin
          estado_reg  <= REPOSO;
          upc_reg     <= DIR_INI;
          control_reg <= '0;
          ocupado_reg <= 1'b0;
        end
      endcase
    end
  end

  assign Dir_Memoria_Micro = upc_reg;
  assign Control_Out       = control_reg;
  assign Ocupado           = ocupado_reg;
  assign Fin               = fin_reg;

endmodule
